// File: rtl/sd_data_ctrl.sv
// SD host DATA-path controller: sequences single/multi-block transfers between DMA, FIFO and
// the DATA phy, with a FIFO-wait timeout, CRC-status check and a sticky error flag.
module sd_data_ctrl #(
    parameter int unsigned BLK_CNT_W = 8,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 writeRead_Regs_DATA,
    input  logic [BLK_CNT_W-1:0] blockCount_Regs_DATA,
    input  logic                 multipleData_Regs_DATA,
    input  logic                 timeout_Enable_Regs_DATA,
    input  logic [TIMEOUT_W-1:0] timeout_Reg_Regs_DATA,
    input  logic                 new_DAT_DMA_DATA,
    input  logic                 serial_Ready_Phy_DATA,
    input  logic                 timeout_Phy_DATA,
    input  logic                 complete_Phy_DATA,
    input  logic                 ack_IN_Phy_DATA,
    input  logic                 fifo_OK_FIFO_DATA,
    output logic                 writeRead_Phy_DATA,
    output logic                 timeout_Enable_Phy_DATA,
    output logic [TIMEOUT_W-1:0] timeout_Reg_Phy_DATA,
    output logic                 strobe_OUT_Phy_DATA,
    output logic                 ack_OUT_Phy_DATA,
    output logic [BLK_CNT_W-1:0] blocks_Done_DATA,
    output logic                 busy_DATA,
    output logic                 transfer_Complete_DATA_DMA,
    output logic                 error_DATA
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCheckFifo,
        StTransmit,
        StAck,
        StDone,
        StError
    } state_e;

    state_e               state_q;
    logic [BLK_CNT_W-1:0] total_q;
    logic [TIMEOUT_W-1:0] wait_q;
    logic                 crc_ok_q;
    logic [BLK_CNT_W-1:0] blocks_next;
    logic [BLK_CNT_W-1:0] total_next;

    always_comb begin
        blocks_next = blocks_Done_DATA + BLK_CNT_W'(1);
        // A zero block count in multi mode still moves one block.
        total_next  = (multipleData_Regs_DATA && (blockCount_Regs_DATA != '0)) ?
                      blockCount_Regs_DATA : BLK_CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q                    <= StIdle;
            total_q                    <= '0;
            wait_q                     <= '0;
            crc_ok_q                   <= 1'b0;
            writeRead_Phy_DATA         <= 1'b0;
            timeout_Enable_Phy_DATA    <= 1'b0;
            timeout_Reg_Phy_DATA       <= '0;
            strobe_OUT_Phy_DATA        <= 1'b0;
            ack_OUT_Phy_DATA           <= 1'b0;
            blocks_Done_DATA           <= '0;
            busy_DATA                  <= 1'b0;
            transfer_Complete_DATA_DMA <= 1'b0;
            error_DATA                 <= 1'b0;
        end else begin
            strobe_OUT_Phy_DATA        <= 1'b0;
            transfer_Complete_DATA_DMA <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (new_DAT_DMA_DATA) begin
                        state_q                 <= StSetup;
                        busy_DATA               <= 1'b1;
                        error_DATA              <= 1'b0;
                        blocks_Done_DATA        <= '0;
                        total_q                 <= total_next;
                        writeRead_Phy_DATA      <= writeRead_Regs_DATA;
                        timeout_Enable_Phy_DATA <= timeout_Enable_Regs_DATA;
                        timeout_Reg_Phy_DATA    <= timeout_Reg_Regs_DATA;
                    end
                end
                StSetup: begin
                    if (serial_Ready_Phy_DATA) begin
                        state_q <= StCheckFifo;
                        wait_q  <= '0;
                    end
                end
                StCheckFifo: begin
                    if (fifo_OK_FIFO_DATA) begin
                        state_q             <= StTransmit;
                        strobe_OUT_Phy_DATA <= 1'b1;
                    end else if (timeout_Enable_Phy_DATA && (wait_q == timeout_Reg_Phy_DATA)) begin
                        state_q    <= StError;
                        error_DATA <= 1'b1;
                    end else begin
                        wait_q <= wait_q + TIMEOUT_W'(1);
                    end
                end
                StTransmit: begin
                    if (timeout_Enable_Phy_DATA && timeout_Phy_DATA) begin
                        state_q    <= StError;
                        error_DATA <= 1'b1;
                    end else if (complete_Phy_DATA) begin
                        state_q          <= StAck;
                        ack_OUT_Phy_DATA <= 1'b1;
                        // CRC status only means something when the card received data.
                        crc_ok_q         <= ack_IN_Phy_DATA || !writeRead_Phy_DATA;
                    end
                end
                StAck: begin
                    if (!complete_Phy_DATA) begin
                        ack_OUT_Phy_DATA <= 1'b0;
                        if (!crc_ok_q) begin
                            state_q    <= StError;
                            error_DATA <= 1'b1;
                        end else begin
                            blocks_Done_DATA <= blocks_next;
                            if (blocks_next == total_q) begin
                                state_q                    <= StDone;
                                transfer_Complete_DATA_DMA <= 1'b1;
                            end else begin
                                state_q <= StCheckFifo;
                                wait_q  <= '0;
                            end
                        end
                    end
                end
                StDone, StError: begin
                    state_q   <= StIdle;
                    busy_DATA <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    busy_DATA <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_data_ctrl.sv
// Self-checking bench for sd_data_ctrl: each transfer is laid out as a cycle-indexed timeline of
// stimulus and expected outputs, replayed against the DUT with a per-cycle compare.
module tb_sd_data_ctrl;
    localparam int unsigned BW = 8;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_reg, multi_reg, ten_reg, new_dat, sready, tphy, cmp, ackin, fifo_ok;
    logic [BW-1:0] bc_reg;
    logic [TW-1:0] treg_reg;
    logic          wr_phy, ten_phy, strobe, ack_out, busy, xfer_done, error;
    logic [TW-1:0] treg_phy;
    logic [BW-1:0] blocks_done;

    always #5 clk = ~clk;

    sd_data_ctrl #(.BLK_CNT_W(BW), .TIMEOUT_W(TW)) dut (
        .CLK                        (clk),
        .RESET                      (rst),
        .writeRead_Regs_DATA        (wr_reg),
        .blockCount_Regs_DATA       (bc_reg),
        .multipleData_Regs_DATA     (multi_reg),
        .timeout_Enable_Regs_DATA   (ten_reg),
        .timeout_Reg_Regs_DATA      (treg_reg),
        .new_DAT_DMA_DATA           (new_dat),
        .serial_Ready_Phy_DATA      (sready),
        .timeout_Phy_DATA           (tphy),
        .complete_Phy_DATA          (cmp),
        .ack_IN_Phy_DATA            (ackin),
        .fifo_OK_FIFO_DATA          (fifo_ok),
        .writeRead_Phy_DATA         (wr_phy),
        .timeout_Enable_Phy_DATA    (ten_phy),
        .timeout_Reg_Phy_DATA       (treg_phy),
        .strobe_OUT_Phy_DATA        (strobe),
        .ack_OUT_Phy_DATA           (ack_out),
        .blocks_Done_DATA           (blocks_done),
        .busy_DATA                  (busy),
        .transfer_Complete_DATA_DMA (xfer_done),
        .error_DATA                 (error)
    );

    typedef struct {
        logic          rst, nd, wr, multi, ten, sready, fifo, tphy, cmp, ackin;
        logic [BW-1:0] bc;
        logic [TW-1:0] treg;
        logic          e_wr, e_ten, e_strobe, e_ackout, e_busy, e_xc, e_err;
        logic [TW-1:0] e_treg;
        logic [BW-1:0] e_bd;
    } cyc_t;

    cyc_t          q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_strobe = 0;
    int            n_xc = 0;
    int            n_busy = 0;
    // Values the outputs show while idle / latched for the current transfer.
    logic          m_wr = 1'b0, m_ten = 1'b0, m_err = 1'b0;
    logic [TW-1:0] m_treg = '0;
    logic [BW-1:0] m_bd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic cyc_t rnd_in();
        cyc_t c;
        c.rst = 1'b0;          c.nd = 1'($urandom);     c.wr = 1'($urandom);
        c.multi = 1'($urandom); c.ten = 1'($urandom);   c.sready = 1'($urandom);
        c.fifo = 1'($urandom);  c.tphy = 1'($urandom);  c.cmp = 1'($urandom);
        c.ackin = 1'($urandom); c.bc = BW'($urandom);   c.treg = TW'($urandom);
        c.e_wr = 1'b0; c.e_ten = 1'b0; c.e_strobe = 1'b0; c.e_ackout = 1'b0;
        c.e_busy = 1'b0; c.e_xc = 1'b0; c.e_err = 1'b0; c.e_treg = '0; c.e_bd = '0;
        return c;
    endfunction

    function automatic cyc_t idle_cyc();
        cyc_t c = rnd_in();
        c.nd = 1'b0;
        c.e_wr = m_wr; c.e_ten = m_ten; c.e_treg = m_treg; c.e_bd = m_bd; c.e_err = m_err;
        return c;
    endfunction

    function automatic cyc_t busy_cyc(input logic [BW-1:0] bd);
        cyc_t c = rnd_in();
        c.e_busy = 1'b1; c.e_bd = bd;
        c.e_wr = m_wr; c.e_ten = m_ten; c.e_treg = m_treg;
        return c;
    endfunction

    // err_kind: 0 none, 1 FIFO timeout, 2 phy timeout, 3 bad CRC (at err_blk), 4 random faults.
    task automatic build(input logic wr, input logic multi, input logic [BW-1:0] bc,
                         input logic ten, input logic [TW-1:0] treg, input int err_kind,
                         input int err_blk, input bit rnd, input logic ack_def);
        cyc_t          c;
        int            total, f, w, h, s;
        logic [BW-1:0] bd;
        bit            tout;
        logic          ack;
        q.delete();
        c = idle_cyc();
        c.nd = 1'b1; c.wr = wr; c.multi = multi; c.bc = bc; c.ten = ten; c.treg = treg;
        q.push_back(c);
        m_wr = wr; m_ten = ten; m_treg = treg;
        total = multi ? ((bc == '0) ? 1 : int'(bc)) : 1;
        bd = '0;
        s = rnd ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i <= s; i++) begin
            c = busy_cyc(bd); c.sready = (i == s); q.push_back(c);
        end
        for (int b = 0; b < total; b++) begin
            f = 0;
            if (rnd) f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12))
                                                     : int'($urandom_range(0, 2));
            if (err_kind == 1 && b == err_blk && ten) f = 1 << 20;
            if (ten && f > int'(treg)) begin
                for (int i = 0; i <= int'(treg); i++) begin
                    c = busy_cyc(bd); c.fifo = 1'b0; q.push_back(c);
                end
                c = busy_cyc(bd); c.e_err = 1'b1; q.push_back(c);
                m_err = 1'b1; m_bd = bd;
                return;
            end
            for (int i = 0; i <= f; i++) begin
                c = busy_cyc(bd); c.fifo = (i == f); q.push_back(c);
            end
            w = rnd ? int'($urandom_range(0, 3)) : 0;
            tout = ten && ((err_kind == 2 && b == err_blk) ||
                           (err_kind == 4 && $urandom_range(0, 15) == 0));
            if (err_kind == 3 && b == err_blk) ack = 1'b0;
            else if (err_kind == 4) ack = ($urandom_range(0, 15) != 0);
            else ack = ack_def;
            for (int i = 0; i <= w; i++) begin
                c = busy_cyc(bd);
                c.e_strobe = (i == 0);
                c.cmp = 1'b0;
                if (ten) c.tphy = 1'b0;
                if (i == w) begin
                    if (tout) begin
                        c.tphy = 1'b1;
                        c.cmp = rnd ? 1'($urandom) : 1'b1;
                    end else begin
                        c.cmp = 1'b1; c.ackin = ack;
                    end
                end
                q.push_back(c);
            end
            if (tout) begin
                c = busy_cyc(bd); c.e_err = 1'b1; q.push_back(c);
                m_err = 1'b1; m_bd = bd;
                return;
            end
            h = rnd ? int'($urandom_range(0, 2)) : 1;
            for (int i = 0; i <= h; i++) begin
                c = busy_cyc(bd); c.e_ackout = 1'b1; c.cmp = (i < h); q.push_back(c);
            end
            if (wr && !ack) begin
                c = busy_cyc(bd); c.e_err = 1'b1; q.push_back(c);
                m_err = 1'b1; m_bd = bd;
                return;
            end
            bd = bd + BW'(1);
        end
        c = busy_cyc(bd); c.e_xc = 1'b1; q.push_back(c);
        m_err = 1'b0; m_bd = bd;
    endtask

    task automatic step(input cyc_t c);
        @(negedge clk);
        rst = c.rst; new_dat = c.nd; wr_reg = c.wr; multi_reg = c.multi; ten_reg = c.ten;
        bc_reg = c.bc; treg_reg = c.treg; sready = c.sready; fifo_ok = c.fifo;
        tphy = c.tphy; cmp = c.cmp; ackin = c.ackin;
        #1;
        chk("wr_phy", 32'(wr_phy), 32'(c.e_wr));
        chk("ten_phy", 32'(ten_phy), 32'(c.e_ten));
        chk("treg_phy", 32'(treg_phy), 32'(c.e_treg));
        chk("strobe", 32'(strobe), 32'(c.e_strobe));
        chk("ack_out", 32'(ack_out), 32'(c.e_ackout));
        chk("blocks_done", 32'(blocks_done), 32'(c.e_bd));
        chk("busy", 32'(busy), 32'(c.e_busy));
        chk("xfer_done", 32'(xfer_done), 32'(c.e_xc));
        chk("error", 32'(error), 32'(c.e_err));
        if (strobe === 1'b1) n_strobe++;
        if (xfer_done === 1'b1) n_xc++;
        if (busy === 1'b1) n_busy++;
    endtask

    task automatic play(input int rst_at);
        cyc_t c;
        for (int k = 0; k < q.size(); k++) begin
            c = q[k];
            if (k == rst_at) c.rst = 1'b1;
            step(c);
            if (k == rst_at) begin
                m_wr = 1'b0; m_ten = 1'b0; m_treg = '0; m_err = 1'b0; m_bd = '0;
                break;
            end
        end
        step(idle_cyc());
    endtask

    // Runs one directed transfer and pins strobe/completion/busy counts to hand-derived values.
    task automatic directed(input string name, input int exp_strb, input int exp_xc,
                            input int exp_busy, input int exp_bd, input int exp_err);
        int s0 = n_strobe, x0 = n_xc, b0 = n_busy;
        play(-1);
        chk({name, "_strobes"}, 32'(n_strobe - s0), 32'(exp_strb));
        chk({name, "_xfer_pulses"}, 32'(n_xc - x0), 32'(exp_xc));
        chk({name, "_busy_cycles"}, 32'(n_busy - b0), 32'(exp_busy));
        chk({name, "_blocks_done"}, 32'(blocks_done), 32'(exp_bd));
        chk({name, "_error"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        cyc_t c;
        int   x0, rst_at;
        c = rnd_in();
        c.rst = 1'b1; c.nd = 1'b0;
        rst = 1'b1; new_dat = 1'b0; wr_reg = 1'b0; multi_reg = 1'b0; ten_reg = 1'b0;
        bc_reg = '0; treg_reg = '0; sready = 1'b0; fifo_ok = 1'b0; tphy = 1'b0;
        cmp = 1'b0; ackin = 1'b0;
        repeat (3) @(negedge clk);
        step(c);
        step(idle_cyc());
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_blocks_done", 32'(blocks_done), 32'd0);

        // Single write.
        build(1'b1, 1'b0, BW'(5), 1'b0, TW'(0), 0, -1, 1'b0, 1'b1);
        directed("single_wr", 1, 1, 6, 1, 0);
        // Multi read of 3 with bad CRC status that must be ignored.
        build(1'b0, 1'b1, BW'(3), 1'b1, TW'(7), 0, -1, 1'b0, 1'b0);
        directed("multi_rd", 3, 1, 14, 3, 0);
        // FIFO never ready, timeout 4: five CHECK_FIFO cycles then ERROR.
        build(1'b1, 1'b0, BW'(0), 1'b1, TW'(4), 1, 0, 1'b0, 1'b1);
        directed("fifo_tmo", 0, 0, 7, 0, 1);
        // Phy timeout together with complete.
        build(1'b1, 1'b1, BW'(2), 1'b1, TW'(10), 2, 0, 1'b0, 1'b1);
        directed("phy_tmo", 1, 0, 4, 0, 1);
        // Bad CRC status on block 2 of 4.
        build(1'b1, 1'b1, BW'(4), 1'b0, TW'(0), 3, 1, 1'b0, 1'b1);
        directed("crc_bad", 2, 0, 10, 1, 1);
        // T=0 with FIFO ready in the first cycle must not time out.
        build(1'b0, 1'b0, BW'(0), 1'b1, TW'(0), 0, -1, 1'b0, 1'b1);
        directed("tmo_zero", 1, 1, 6, 1, 0);

        // Reset during TRANSMIT of block 2, then a clean transfer.
        build(1'b1, 1'b1, BW'(3), 1'b1, TW'(9), 0, -1, 1'b0, 1'b1);
        x0 = n_xc;
        play(7);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_xfer_pulses", 32'(n_xc - x0), 32'd0);
        chk("rst_mid_wr_phy", 32'(wr_phy), 32'd0);
        build(1'b1, 1'b0, BW'(0), 1'b0, TW'(0), 0, -1, 1'b0, 1'b1);
        directed("after_rst", 1, 1, 6, 1, 0);

        for (int t = 0; t < 150; t++) begin
            int gap = int'($urandom_range(0, 2));
            int ek  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 4;
            for (int g = 0; g < gap; g++) step(idle_cyc());
            build(1'($urandom), 1'($urandom), BW'($urandom_range(0, 5)), 1'($urandom),
                  TW'($urandom_range(0, 15)), ek, int'($urandom_range(0, 4)), 1'b1, 1'b1);
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, q.size() - 1)) : -1;
            play(rst_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_data_ctrl.md
# sd_data_ctrl

Parametrised data-path controller for the SD host DATA block. It sits between the register file, the DMA, the data FIFO and the DATA physical layer, and sequences single- or multi-block reads and writes. It is the next generation of the single-block DATA control flow, adding:
- a configurable block-count width;
- looping over N blocks;
- an internal FIFO-wait timeout;
- CRC-status checking;
- explicit error reporting.

## Interface
Parameters:
- BLK_CNT_W, 8, width of block count and blocks-done counter
- TIMEOUT_W, 16, width of timeout register and internal wait counter

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- writeRead_Regs_DATA  in  1  1 = write (FIFO to card), 0 = read
- blockCount_Regs_DATA  in  BLK_CNT_W  blocks to transfer in multi mode
- multipleData_Regs_DATA  in  1  1 = multi-block, 0 = single block
- timeout_Enable_Regs_DATA  in  1  enables both timeouts
- timeout_Reg_Regs_DATA  in  TIMEOUT_W  timeout limit in CLK cycles
- new_DAT_DMA_DATA  in  1  transfer request from DMA (level)
- serial_Ready_Phy_DATA  in  1  physical layer ready
- timeout_Phy_DATA  in  1  physical-layer timeout
- complete_Phy_DATA  in  1  physical layer finished a block (level)
- ack_IN_Phy_DATA  in  1  CRC status good, valid while complete_Phy_DATA=1
- fifo_OK_FIFO_DATA  in  1  FIFO can supply/accept a full block
- writeRead_Phy_DATA  out  1  latched direction to physical layer
- timeout_Enable_Phy_DATA  out  1  latched timeout enable
- timeout_Reg_Phy_DATA  out  TIMEOUT_W  latched timeout value
- strobe_OUT_Phy_DATA  out  1  one-cycle block-start pulse
- ack_OUT_Phy_DATA  out  1  acknowledge of complete_Phy_DATA
- blocks_Done_DATA  out  BLK_CNT_W  blocks completed in current transfer
- busy_DATA  out  1  high in every state except IDLE
- transfer_Complete_DATA_DMA  out  1  one-cycle pulse on successful end
- error_DATA  out  1  sticky error flag

## Operation
- States: IDLE, SETUP, CHECK_FIFO, TRANSMIT, ACK, DONE, ERROR.
- IDLE → SETUP on new_DAT_DMA_DATA=1.
  - On that edge, latch direction, multi flag, timeout enable/value and block count.
  - Total blocks = multi ? blockCount : 1; a blockCount of 0 in multi mode is treated as 1.
  - Clear error_DATA and blocks_Done_DATA.
- SETUP: drive the latched Phy outputs; → CHECK_FIFO when serial_Ready_Phy_DATA=1.
- CHECK_FIFO: the wait counter is cleared on entry and increments each cycle.
  - fifo_OK_FIFO_DATA=1 → TRANSMIT; fifo_OK takes priority over timeout.
  - Else, if timeout enabled and counter == timeout_Reg → ERROR.
- TRANSMIT: strobe_OUT_Phy_DATA=1 on the first cycle only.
  - timeout_Phy_DATA=1 (when enabled) → ERROR; this takes priority over complete.
  - Else complete_Phy_DATA=1 → ACK, latching ack_IN_Phy_DATA as CRC status (checked in write mode only).
- ACK: ack_OUT_Phy_DATA=1; wait for complete_Phy_DATA=0.
  - CRC status bad → ERROR.
  - Else increment blocks_Done_DATA; if blocks_Done+1 == total → DONE, else → CHECK_FIFO.
- DONE: transfer_Complete_DATA_DMA=1 for one cycle → IDLE.
- ERROR: set error_DATA; one cycle → IDLE.
- new_DAT_DMA_DATA and register inputs are ignored while busy.
- The next transfer starts only when new_DAT_DMA_DATA is seen in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0; wait counter 0.
- RESET mid-transfer aborts with no completion pulse and no error.
- All outputs are registered.
- SETUP is entered one cycle after new_DAT is sampled.
- strobe is asserted in the cycle after fifo_OK is sampled high.
- Timeout: with timeout_Reg=T, fifo_OK must rise within T+1 cycles of CHECK_FIFO entry; T=0 errors on the first cycle unless fifo_OK=1.
- blocks_Done_DATA updates on the ACK→next-state edge and wraps modulo 2^BLK_CNT_W (unreachable with a latched total).
- error_DATA holds until the next accepted new_DAT_DMA_DATA or RESET.
- Minimum per-block loop: CHECK_FIFO, TRANSMIT, ACK, one cycle each.

## Test plan
- Single write: RESET, new_DAT=1, serial_Ready, fifo_OK, complete high then low, ack_IN=1 → one strobe, ack_OUT high until complete falls, blocks_Done=1, one transfer_Complete pulse, error=0.
- Multi read, blockCount=3: three complete/ack handshakes (ack_IN=0 ignored in read) → three strobes, blocks_Done 1,2,3, single completion pulse after the third.
- FIFO timeout: enable=1, timeout_Reg=4, fifo_OK held 0 → ERROR 5 cycles after CHECK_FIFO entry, error_DATA=1, no strobe, no completion pulse.
- Phy timeout and complete asserted in the same TRANSMIT cycle → ERROR taken, blocks_Done unchanged.
- Write with ack_IN=0 on block 2 of 4 → blocks_Done=1, error_DATA=1, return to IDLE.
- RESET during TRANSMIT of block 2 → next cycle all outputs 0, IDLE; a fresh transfer then completes normally.
